// File: rtl/gray_xcodec.sv
// -----------------------------------------------------------------------------
// gray_xcodec
//   Streaming binary<->Gray transcoder with a two-stage valid/ready pipeline.
//   Each accepted beat carries its own mode, so encode and decode beats can be
//   freely interleaved. The output stage also reports whether the word differs
//   from the previously produced word in exactly one bit (Gray adjacency).
//
// Parameters
//   WIDTH  data width in bits (2..64)
//   CNT_W  width of the completed-beat counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = binary->Gray encode, 1 = Gray->binary decode (per beat)
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat (combinational from out_ready)
//   in_data    input word
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   transformed word
//   out_adj    out_data differs from the previous output word in one bit
//   out_first  first output word since reset (no previous word exists)
//   beat_cnt   completed output handshakes, saturating
// -----------------------------------------------------------------------------
module gray_xcodec #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_adj,
  output logic             out_first,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // g[i] = b[i] ^ b[i+1]; the MSB passes straight through.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH-1; i++) begin
      g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  // Prefix XOR running down from the MSB.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit is set: nonzero and clearing the lowest set
  // bit leaves nothing behind.
  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - ONE_W)) == '0);
  endfunction

  logic             vld_p1_q,   vld_p1_d;
  logic [WIDTH-1:0] data_p1_q,  data_p1_d;
  logic             vld_p2_q,   vld_p2_d;
  logic [WIDTH-1:0] data_p2_q,  data_p2_d;
  logic             adj_p2_q,   adj_p2_d;
  logic             first_p2_q, first_p2_d;
  logic [WIDTH-1:0] prev_q,     prev_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic s2_load;
  logic s1_load;
  logic accept;
  logic complete;

  always_comb begin
    s2_load  = !vld_p2_q || out_ready;
    s1_load  = !vld_p1_q || s2_load;
    accept   = in_valid && s1_load;
    complete = vld_p2_q && out_ready;

    vld_p1_d    = vld_p1_q;
    data_p1_d   = data_p1_q;
    vld_p2_d    = vld_p2_q;
    data_p2_d   = data_p2_q;
    adj_p2_d    = adj_p2_q;
    first_p2_d  = first_p2_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    beat_cnt_d  = beat_cnt_q;

    // Stage 1: transform on acceptance; data only moves with a real beat.
    if (s1_load) begin
      vld_p1_d = accept;
      if (accept) begin
        data_p1_d = mode ? gray2bin(in_data) : bin2gray(in_data);
      end
    end

    // Stage 2: output word plus adjacency flags against the last loaded word.
    if (s2_load) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d   = data_p1_q;
        adj_p2_d    = have_prev_q && is_onehot(data_p1_q ^ prev_q);
        first_p2_d  = !have_prev_q;
        prev_d      = data_p1_q;
        have_prev_d = 1'b1;
      end
    end

    if (complete && (beat_cnt_q != CNT_MAX)) begin
      beat_cnt_d = beat_cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      adj_p2_q    <= 1'b0;
      first_p2_q  <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      data_p2_q   <= data_p2_d;
      adj_p2_q    <= adj_p2_d;
      first_p2_q  <= first_p2_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
  end

  assign in_ready  = s1_load;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_adj   = adj_p2_q;
  assign out_first = first_p2_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_gray_xcodec.sv
module tb_gray_xcodec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic        in_ready, out_valid, out_adj, out_first;
  logic [5:0]  out_data;
  logic [15:0] beat_cnt;

  logic        s_in_ready, s_out_valid, s_out_adj, s_out_first;
  logic [5:0]  s_out_data;
  logic [2:0]  s_beat_cnt;

  gray_xcodec #(.WIDTH(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_adj(out_adj),
    .out_first(out_first), .beat_cnt(beat_cnt)
  );

  gray_xcodec #(.WIDTH(6), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_adj(s_out_adj),
    .out_first(s_out_first), .beat_cnt(s_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] d;
    logic       adj;
    logic       first;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         errors = 0;
  int         cnt = 0;
  logic [5:0] m_prev = '0;
  bit         m_have_prev = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_dec(input logic [5:0] g);
    logic [5:0] b = '0;
    for (int i = 0; i < 6; i++) b ^= g >> i;
    return b;
  endfunction

  function automatic void m_push(input bit m, input logic [5:0] x);
    exp_t e;
    e.d     = m ? m_dec(x) : (x ^ (x >> 1));
    e.adj   = m_have_prev && ($countones(e.d ^ m_prev) == 1);
    e.first = !m_have_prev;
    m_prev      = e.d;
    m_have_prev = 1;
    q.push_back(e);
  endfunction

  // Output monitor / scoreboard checker.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("beat_cnt", 64'(beat_cnt), 64'(cnt));
      chk("beat_cnt_sat", 64'(s_beat_cnt), 64'(cnt > 7 ? 7 : cnt));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          chk("out_data", 64'(out_data), 64'(q[0].d));
          chk("out_adj", 64'(out_adj), 64'(q[0].adj));
          chk("out_first", 64'(out_first), 64'(q[0].first));
          chk("s_out_valid", 64'(s_out_valid), 64'(1));
          chk("s_out_data", 64'(s_out_data), 64'(q[0].d));
          chk("s_out_flags", 64'({s_out_adj, s_out_first}), 64'({q[0].adj, q[0].first}));
          if (out_ready) begin
            void'(q.pop_front());
            cnt++;
          end
        end
      end
    end
  end

  // Drive one beat, hold until accepted (bounded), then drop in_valid.
  task automatic send(input bit m, input logic [5:0] x);
    bit done = 0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = x;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      chk("in_ready_pair", 64'(s_in_ready), 64'(in_ready));
      if (in_ready) begin
        m_push(m, x);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
    mode     = 1'($urandom);
    in_data  = 6'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_flags", 64'({out_adj, out_first}), 64'(0));
    chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    rst_n = 1'b1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Encode 101101 with latency check
    send(0, 6'b101101);
    @(negedge clk);
    chk("latency_c1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("latency_c2", 64'(out_valid), 64'(1));
    chk("enc_word", 64'(out_data), 64'(6'b111011));
    @(posedge clk);
    #1;
    drain();
    chk("enc_beat_cnt", 64'(beat_cnt), 64'(1));

    // Decode
    send(1, 6'b111011);
    drain();

    // Adjacency
    send(0, 6'd5);
    send(0, 6'd6);
    send(0, 6'd0);
    send(0, 6'd5);
    drain();

    // Round-trip sweep, mixed modes back-to-back
    for (int v = 0; v < 64; v++) begin
      send(0, 6'(v));
      send(1, 6'(v) ^ (6'(v) >> 1));
    end
    drain();

    // Backpressure: fill both stages, check stall, then release
    out_ready = 1'b0;
    send(0, 6'd10);
    send(1, 6'd11);
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("bp_stall_data", 64'(out_data), 64'(6'd10 ^ 6'd5));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(k[0], 6'(20 + k));
    drain();

    // Random backpressure stream
    fork
      for (int k = 0; k < 20; k++) send(1'($urandom), 6'($urandom));
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(0, 6'd33);
    send(0, 6'd34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_cnt", 64'(beat_cnt), 64'(0));
    chk("mid_rst_cnt_sat", 64'(s_beat_cnt), 64'(0));
    chk("mid_rst_out", 64'({out_data, out_adj, out_first}), 64'(0));
    q.delete();
    cnt = 0;
    m_have_prev = 0;
    m_prev = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    send(0, 6'd7);
    drain();

    // Saturation of the narrow counter
    for (int k = 0; k < 10; k++) send(0, 6'(k));
    drain();
    chk("sat_cnt", 64'(s_beat_cnt), 64'(7));
    chk("wide_cnt", 64'(beat_cnt), 64'(11));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gray_xcodec.md
GRAY_XCODEC -- requirements
Module: gray_xcodec

Interface
REQ-001 SHALL have parameter WIDTH, default 6: data width in bits, legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mode, input, 1 bit: 0 = binary-to-Gray encode, 1 = Gray-to-binary decode; sampled with each accepted beat.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-008 SHALL have port in_data, input, WIDTH bits: input word.
REQ-009 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 SHALL have port out_data, output, WIDTH bits: transformed word.
REQ-012 SHALL have port out_adj, output, 1 bit: out_data differs from the previous output word in exactly one bit.
REQ-013 SHALL have port out_first, output, 1 bit: first beat since reset, so no previous word exists.
REQ-014 SHALL have port beat_cnt, output, CNT_W bits: count of completed output handshakes.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready, and complete a beat when out_valid && out_ready.
REQ-016 SHALL use a two-stage pipeline: S1 holds the transformed word; S2 holds the output word and its flags.
REQ-017 SHALL load S2 when (!S2.valid || out_ready), and load S1 when (!S1.valid || S2 loads).
REQ-018 SHALL drive in_ready = !S1.valid || S2-load-condition; in_ready is combinational from out_ready, with no other combinational input-to-output paths.
REQ-019 SHALL, with no backpressure, present an accepted beat on out_valid exactly 2 cycles after acceptance, sustaining 1 beat/cycle.
REQ-020 SHALL, in encode mode, produce S1 word g[i] = b[i] ^ b[i+1] for i < WIDTH-1, and g[WIDTH-1] = b[WIDTH-1].
REQ-021 SHALL, in decode mode, produce S1 word b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i] (prefix XOR from the MSB).
REQ-022 SHALL carry mode per beat, so mixed-mode streams are processed correctly with no flush.
REQ-023 SHALL keep a register prev holding the last word loaded into S2, and a register have_prev.
REQ-024 SHALL, on S2 load, set out_adj = have_prev && (popcount(word ^ prev) == 1), set out_first = !have_prev, update prev to the word, and set have_prev = 1.
REQ-025 SHALL hold out_data, out_adj and out_first stable while out_valid && !out_ready.
REQ-026 SHALL, for a simultaneous S2 completion and new S2 load, make the new word visible on the next cycle with no bubble.
REQ-027 SHALL increment beat_cnt on each output handshake, saturating at 2^CNT_W-1; it SHALL NOT wrap.
REQ-028 SHALL ignore in_data and mode when no beat is accepted, and SHALL leave all state unchanged when idle.

Reset
REQ-029 SHALL, on rst_n low, immediately clear S1.valid, S2.valid, out_valid, out_data, out_adj, out_first, prev, have_prev and beat_cnt to 0, independent of clk.
REQ-030 SHALL, on reset mid-operation, discard in-flight beats; the first beat after release SHALL report out_first=1 and out_adj=0.
REQ-031 SHALL drive in_ready=1 from the first cycle after rst_n deasserts.

Verification
REQ-032 Encode, WIDTH=6: mode=0, in_data=6'b101101 -> out_data=6'b111011 two cycles later, out_first=1, out_adj=0, beat_cnt=1.
REQ-033 Decode round-trip: mode=1, in_data=6'b111011 -> out_data=6'b101101; sweep all 64 values encode-then-decode -> identity.
REQ-034 Adjacency: encode 5 then 6 back-to-back -> outputs 000111 and 000101, second beat out_adj=1; then encode 0 then 5 -> second beat out_adj=0.
REQ-035 Backpressure: stream 8 beats with out_ready held low for 3 cycles -> in_ready drops once S1 and S2 are full, with no loss, duplication or reordering; out_data stays stable while stalled.
REQ-036 Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 and beat_cnt=0 immediately; next beat has out_first=1.
REQ-037 Saturation: CNT_W=3, complete 10 beats -> beat_cnt=7.
